operand_fetch: RTL
==================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter: WORD_LENGTH, 32, datapath width of registers and operands.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  decoded instruction fields valid this cycle.
REQ-005 in_ready  output  1  stage can accept an instruction this cycle.
REQ-006 rs1_addr, rs2_addr  input  5 each  source register indices.
REQ-007 rd_addr_in  input  5  destination index, carried through.
REQ-008 imm  input  32  sign-extended immediate from decode.
REQ-009 pc  input  32  instruction address.
REQ-010 use_imm, use_pc  input  1 each  select imm for in_2, pc for in_1.
REQ-011 alu_op_in  input  4  ALU function select; sub_en  input  1  subtract/compare request.
REQ-012 wb_en  input  1; wb_addr  input  5; wb_data  input  32  register-file write port.
REQ-013 out_valid  output  1; out_ready  input  1  downstream handshake to the ALU stage.
REQ-014 in_1, in_2  output  32 each  ALU operands; cin  output  1; op_mux_ctrl  output  4.
REQ-015 rd_addr  output  5; rs2_data  output  32  destination index and raw rs2 value (store data).

Function
REQ-016 Register file SHALL hold 32 x WORD_LENGTH entries; entry 0 SHALL always read 0 and ignore writes.
REQ-017 Write SHALL occur on the rising edge when wb_en=1 and wb_addr!=0.
REQ-018 Read SHALL bypass: if wb_en=1, wb_addr!=0 and wb_addr equals a source index in the same cycle, that operand SHALL be wb_data.
REQ-019 Accept SHALL occur when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-020 On accept, output register SHALL load: in_1 = use_pc ? pc : rs1 value; in_2 = use_imm ? imm : rs2 value; cin = sub_en; op_mux_ctrl = alu_op_in; rd_addr = rd_addr_in; rs2_data = rs2 value.
REQ-021 Latency SHALL be exactly one cycle from accept to out_valid=1.
REQ-022 out_valid SHALL set on accept, clear on out_valid && out_ready with no new accept, and stay 1 on simultaneous drain and accept (back-to-back, full throughput).
REQ-023 While out_valid=1 and out_ready=0, all outputs SHALL hold stable; later register writes SHALL NOT alter captured operands.
REQ-024 in_2 SHALL be passed un-inverted when sub_en=1; inversion and carry-in are owned by the ALU.
REQ-025 Shift ops (op codes 1, 5, 6) SHALL pass full in_2; only bits [4:0] are consumed downstream.
REQ-026 Write-back SHALL proceed independently of the handshake, including during stall.
REQ-027 in_valid=0 SHALL leave outputs and out_valid unchanged except for drain per REQ-022.

Reset
REQ-028 On rst_n=0, asynchronously: out_valid=0, in_1=in_2=rs2_data=0, cin=0, op_mux_ctrl=0, rd_addr=0, all 32 register entries=0.
REQ-029 Reset asserted mid-transfer SHALL discard the held instruction; first accept allowed in the first cycle after rst_n rises.

Structure
REQ-030 Shared package SHALL hold WORD_LENGTH, REG_ADDR_W=5, and ALU op constants: ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL=5, SRA=6, OR=7, AND=8.
REQ-031 Register file SHALL be a sub-module named reg_file (2 read, 1 write, bypass included); handshake/output register stays in operand_fetch.

Verification
REQ-032 Reset then read x5 with rs1=rs2=5 -> in_1=0, in_2=0, out_valid=1 one cycle after accept.
REQ-033 Write x3=0x0000_00AA, next cycle accept rs1=3, use_imm=1, imm=0xFFFF_FFFC -> in_1=0x0000_00AA, in_2=0xFFFF_FFFC.
REQ-034 Same-cycle wb_en=1, wb_addr=7, wb_data=0x1234_5678 and accept rs2=7 -> in_2=0x1234_5678; wb_addr=0, wb_data=0xDEAD_BEEF then read x0 -> 0.
REQ-035 out_ready=0 for 3 cycles with valid output, write x1 meanwhile -> outputs unchanged, in_ready=0; out_ready=1 -> drains, in_ready=1.
REQ-036 Continuous in_valid=1, out_ready=1 over 4 instructions (SUB with sub_en=1, SLL, SRA, AND) -> one output per cycle, cin=1 only on SUB, op_mux_ctrl 0,1,6,8 in order.
REQ-037 Assert rst_n=0 while out_valid=1 and stalled -> out_valid=0 immediately, register file cleared.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared widths and ALU function codes for the operand-fetch stage and its register file.
package operand_fetch_pkg;

    localparam int WORD_LENGTH = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int NUM_REGS    = 1 << REG_ADDR_W;
    localparam int ALU_OP_W    = 4;

    // ALU function select codes, as carried on op_mux_ctrl.
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SLL  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_SRA  = 4'd6,
        ALU_OR   = 4'd7,
        ALU_AND  = 4'd8
    } alu_op_e;

endpackage

// File: rtl/reg_file.sv
// 32-entry register file: two combinational read ports with write-through bypass,
// one synchronous write port. Entry 0 is hardwired to zero.
module reg_file #(
    parameter int WORD_LENGTH = operand_fetch_pkg::WORD_LENGTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [operand_fetch_pkg::REG_ADDR_W-1:0] raddr1_i,
    input  logic [operand_fetch_pkg::REG_ADDR_W-1:0] raddr2_i,
    output logic [WORD_LENGTH-1:0]               rdata1_o,
    output logic [WORD_LENGTH-1:0]               rdata2_o,
    input  logic                                 we_i,
    input  logic [operand_fetch_pkg::REG_ADDR_W-1:0] waddr_i,
    input  logic [WORD_LENGTH-1:0]               wdata_i
);
    import operand_fetch_pkg::*;

    logic [WORD_LENGTH-1:0] regs_q [NUM_REGS];
    logic                   wr_active;

    assign wr_active = we_i && (waddr_i != '0);

    // Storage: cleared on reset, written on the rising edge; writes to x0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_active) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports: x0 reads zero, a same-cycle write to the read index is forwarded.
    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        rdata2_o = regs_q[raddr2_i];
        if (raddr1_i == '0) begin
            rdata1_o = '0;
        end else if (wr_active && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
        if (raddr2_i == '0) begin
            rdata2_o = '0;
        end else if (wr_active && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads the register file, selects ALU operands and holds them
// in a single valid/ready output register toward the ALU stage.
module operand_fetch #(
    parameter int WORD_LENGTH = operand_fetch_pkg::WORD_LENGTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             rs1_addr,
    input  logic [4:0]             rs2_addr,
    input  logic [4:0]             rd_addr_in,
    input  logic [WORD_LENGTH-1:0] imm,
    input  logic [WORD_LENGTH-1:0] pc,
    input  logic                   use_imm,
    input  logic                   use_pc,
    input  logic [3:0]             alu_op_in,
    input  logic                   sub_en,
    input  logic                   wb_en,
    input  logic [4:0]             wb_addr,
    input  logic [WORD_LENGTH-1:0] wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] in_1,
    output logic [WORD_LENGTH-1:0] in_2,
    output logic                   cin,
    output logic [3:0]             op_mux_ctrl,
    output logic [4:0]             rd_addr,
    output logic [WORD_LENGTH-1:0] rs2_data
);
    import operand_fetch_pkg::*;

    logic [WORD_LENGTH-1:0] rs1_val;
    logic [WORD_LENGTH-1:0] rs2_val;
    logic                   accept;

    logic                   valid_q,    valid_d;
    logic [WORD_LENGTH-1:0] in1_q,      in1_d;
    logic [WORD_LENGTH-1:0] in2_q,      in2_d;
    logic                   cin_q,      cin_d;
    logic [ALU_OP_W-1:0]    op_q,       op_d;
    logic [REG_ADDR_W-1:0]  rd_q,       rd_d;
    logic [WORD_LENGTH-1:0] rs2data_q,  rs2data_d;

    // Write-back runs regardless of the handshake, so stalls never block it.
    reg_file #(.WORD_LENGTH(WORD_LENGTH)) u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1_i (rs1_addr),
        .raddr2_i (rs2_addr),
        .rdata1_o (rs1_val),
        .rdata2_o (rs2_val),
        .we_i     (wb_en),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Next state: load on accept, drop valid on a drain without refill, otherwise hold.
    always_comb begin
        valid_d   = valid_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        cin_d     = cin_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rs2data_d = rs2data_q;
        if (accept) begin
            valid_d   = 1'b1;
            in1_d     = use_pc  ? pc  : rs1_val;
            in2_d     = use_imm ? imm : rs2_val;
            cin_d     = sub_en;
            op_d      = alu_op_in;
            rd_d      = rd_addr_in;
            rs2data_d = rs2_val;
        end else if (valid_q && out_ready) begin
            valid_d   = 1'b0;
        end
    end

    // Output register toward the ALU stage; reset discards any held instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            in1_q     <= '0;
            in2_q     <= '0;
            cin_q     <= 1'b0;
            op_q      <= '0;
            rd_q      <= '0;
            rs2data_q <= '0;
        end else begin
            valid_q   <= valid_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            cin_q     <= cin_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            rs2data_q <= rs2data_d;
        end
    end

    assign out_valid   = valid_q;
    assign in_1        = in1_q;
    assign in_2        = in2_q;
    assign cin         = cin_q;
    assign op_mux_ctrl = op_q;
    assign rd_addr     = rd_q;
    assign rs2_data    = rs2data_q;

endmodule
